// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: ID-stage branch resolution for the pipelined CPU.
// Resolves beq/bne from forwarded operands and holds ID while either
// operand is still pending. A taken branch raises a registered PC redirect
// toward fetch over a valid/ready handshake, and the wrong-path ID
// instruction is flushed in the acceptance cycle. There is no delay slot.
// Optional build macro: BRANCH_STATS_EN adds saturating 32-bit counters
// stat_branches, stat_taken and stat_stall_cycles.
module branch_resolve_ctrl #(
  parameter int DW    = 32,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_is_beq,
  input  logic             id_is_bne,
  input  logic [DW-1:0]    id_pc4,
  input  logic [IMM_W-1:0] id_imm,
  input  logic [DW-1:0]    rs_val,
  input  logic [DW-1:0]    rt_val,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic             fetch_ready,
  output logic             redirect_valid,
  output logic [DW-1:0]    redirect_pc,
  output logic             stall_id,
  output logic             flush_id
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_taken,
  output logic [31:0]      stat_stall_cycles
`endif
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_OPND = 2'd1;
  localparam logic [1:0] REDIRECT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             br_beq_q, br_beq_d;
  logic [DW-1:0]    br_pc4_q, br_pc4_d;
  logic [IMM_W-1:0] br_imm_q, br_imm_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [DW-1:0]    redirect_pc_q, redirect_pc_d;

  logic             is_br;
  logic             opnd_ready;
  logic             sel_beq;
  logic [DW-1:0]    sel_pc4;
  logic [IMM_W-1:0] sel_imm;
  logic [DW-1:0]    opnd_diff;
  logic             opnd_eq;
  logic             taken;
  logic [DW-1:0]    br_offset;
  logic [DW-1:0]    br_target;
  logic             resolve;
  logic             stall_raw;
  logic             flush_raw;

  // Decode the ID instruction; beq wins when both type bits are set.
  always_comb begin
    is_br      = id_valid & (id_is_beq | id_is_bne);
    opnd_ready = rs_ready & rt_ready;
  end

  // Branch fields come from ID in IDLE and from the latched copy in WAIT_OPND.
  always_comb begin
    if (state_q == WAIT_OPND) begin
      sel_beq = br_beq_q;
      sel_pc4 = br_pc4_q;
      sel_imm = br_imm_q;
    end else begin
      sel_beq = id_is_beq;
      sel_pc4 = id_pc4;
      sel_imm = id_imm;
    end
  end

  // Full-width equality via subtraction, then the taken decision.
  always_comb begin
    opnd_diff = rs_val - rt_val;
    opnd_eq   = (opnd_diff == '0);
    taken     = sel_beq ? opnd_eq : ~opnd_eq;
  end

  // Target = pc4 + (sext(imm) << 2); overflow wraps silently.
  always_comb begin
    br_offset = {{(DW-IMM_W){sel_imm[IMM_W-1]}}, sel_imm} << 2;
    br_target = sel_pc4 + br_offset;
  end

  // FSM next-state, branch latch, redirect register and stall/flush decode.
  always_comb begin
    state_d          = state_q;
    br_beq_d         = br_beq_q;
    br_pc4_d         = br_pc4_q;
    br_imm_d         = br_imm_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    stall_raw        = 1'b0;
    flush_raw        = 1'b0;
    resolve          = 1'b0;

    case (state_q)
      IDLE: begin
        if (is_br) begin
          if (!opnd_ready) begin
            stall_raw = 1'b1;
            br_beq_d  = id_is_beq;
            br_pc4_d  = id_pc4;
            br_imm_d  = id_imm;
            state_d   = WAIT_OPND;
          end else begin
            resolve = 1'b1;
            if (taken) begin
              redirect_valid_d = 1'b1;
              redirect_pc_d    = br_target;
              state_d          = REDIRECT;
            end
          end
        end
      end

      WAIT_OPND: begin
        if (!opnd_ready) begin
          stall_raw = 1'b1;
        end else begin
          resolve = 1'b1;
          if (taken) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = br_target;
            state_d          = REDIRECT;
          end else begin
            state_d = IDLE;
          end
        end
      end

      REDIRECT: begin
        // The instruction in ID here is wrong-path and is never evaluated.
        if (fetch_ready) begin
          flush_raw        = 1'b1;
          redirect_valid_d = 1'b0;
          state_d          = IDLE;
        end else begin
          stall_raw = 1'b1;
        end
      end

      default: begin
        redirect_valid_d = 1'b0;
        state_d          = IDLE;
      end
    endcase
  end

  // Stall and flush are combinational; rst_n gates them so every output is 0 in reset.
  always_comb begin
    stall_id       = stall_raw & rst_n;
    flush_id       = flush_raw & rst_n;
    redirect_valid = redirect_valid_q;
    redirect_pc    = redirect_pc_q;
  end

  // State and branch registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      br_beq_q         <= 1'b0;
      br_pc4_q         <= '0;
      br_imm_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      br_beq_q         <= br_beq_d;
      br_pc4_q         <= br_pc4_d;
      br_imm_q         <= br_imm_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_taken_q, stat_taken_d;
  logic [31:0] stat_stall_cycles_q, stat_stall_cycles_d;

  // Saturating event counters for resolved branches, taken branches and stall cycles.
  always_comb begin
    stat_branches_d     = stat_branches_q;
    stat_taken_d        = stat_taken_q;
    stat_stall_cycles_d = stat_stall_cycles_q;
    if (resolve && (stat_branches_q != '1)) begin
      stat_branches_d = stat_branches_q + 32'd1;
    end
    if (resolve && taken && (stat_taken_q != '1)) begin
      stat_taken_d = stat_taken_q + 32'd1;
    end
    if (stall_raw && (stat_stall_cycles_q != '1)) begin
      stat_stall_cycles_d = stat_stall_cycles_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q     <= '0;
      stat_taken_q        <= '0;
      stat_stall_cycles_q <= '0;
    end else begin
      stat_branches_q     <= stat_branches_d;
      stat_taken_q        <= stat_taken_d;
      stat_stall_cycles_q <= stat_stall_cycles_d;
    end
  end

  // Counter outputs.
  always_comb begin
    stat_branches     = stat_branches_q;
    stat_taken        = stat_taken_q;
    stat_stall_cycles = stat_stall_cycles_q;
  end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl: a table of
// single-branch vectors plus hand-written multi-cycle sequences.
module tb_branch_resolve_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_is_beq;
  logic        id_is_bne;
  logic [31:0] id_pc4;
  logic [15:0] id_imm;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rs_ready;
  logic        rt_ready;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_id;
  logic        flush_id;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_taken;
  logic [31:0] stat_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  branch_resolve_ctrl #(.DW(32), .IMM_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_is_beq      (id_is_beq),
    .id_is_bne      (id_is_bne),
    .id_pc4         (id_pc4),
    .id_imm         (id_imm),
    .rs_val         (rs_val),
    .rt_val         (rt_val),
    .rs_ready       (rs_ready),
    .rt_ready       (rt_ready),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_id       (stall_id),
    .flush_id       (flush_id)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches     (stat_branches),
    .stat_taken        (stat_taken),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        beq;
    logic        bne;
    logic [31:0] pc4;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        rs_rdy;
    logic        rt_rdy;
    logic        exp_stall;
    logic        exp_rv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic b, input logic n,
                              input logic [31:0] pc4, input logic [15:0] imm,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic rsr, input logic rtr,
                              input logic es, input logic erv, input logic [31:0] epc);
    vec_t t;
    t.valid = v; t.beq = b; t.bne = n; t.pc4 = pc4; t.imm = imm;
    t.rs = rs; t.rt = rt; t.rs_rdy = rsr; t.rt_rdy = rtr;
    t.exp_stall = es; t.exp_rv = erv; t.exp_pc = epc;
    return t;
  endfunction

  task automatic drive_br(input logic v, input logic b, input logic n,
                          input logic [31:0] pc4, input logic [15:0] imm,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic rsr, input logic rtr);
    id_valid = v; id_is_beq = b; id_is_bne = n; id_pc4 = pc4; id_imm = imm;
    rs_val = rs; rt_val = rt; rs_ready = rsr; rt_ready = rtr;
  endtask

  task automatic idle_inputs();
    drive_br(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 32'h0, 32'h0, 1'b1, 1'b1);
  endtask

  initial begin
    //              v  beq  bne  pc4           imm      rs            rt        rsr  rtr  stall rv  pc
    vecs[0] = mk(1, 1, 0, 32'h0040_0010, 16'h0003, 32'h1234,     32'h1234, 1, 1, 0, 1, 32'h0040_001C);
    vecs[1] = mk(1, 0, 1, 32'h0000_1000, 16'h0004, 32'h5,        32'h5,    1, 1, 0, 0, 32'h0);
    vecs[2] = mk(1, 0, 1, 32'hFFFF_FFF0, 16'h0008, 32'h1,        32'h2,    1, 1, 0, 1, 32'h0000_0010);
    vecs[3] = mk(1, 1, 0, 32'h0000_2000, 16'h0004, 32'h1,        32'h2,    1, 1, 0, 0, 32'h0);
    vecs[4] = mk(1, 1, 0, 32'h0002_0000, 16'h8000, 32'hABCD,     32'hABCD, 1, 1, 0, 1, 32'h0000_0000);
    vecs[5] = mk(1, 1, 1, 32'h0000_0100, 16'hFFFF, 32'h9,        32'h9,    1, 1, 0, 1, 32'h0000_00FC);
    vecs[6] = mk(0, 1, 0, 32'h0000_0100, 16'h0001, 32'h9,        32'h9,    1, 1, 0, 0, 32'h0);
    vecs[7] = mk(1, 1, 0, 32'h0000_0200, 16'h0001, 32'h1,        32'h2,    0, 1, 1, 0, 32'h0);
    vecs[8] = mk(1, 0, 1, 32'h0000_1000, 16'h0010, 32'h8000_0000, 32'h0,   1, 1, 0, 1, 32'h0000_1040);
    vecs[9] = mk(1, 0, 1, 32'hFFFF_FFFC, 16'h0002, 32'h3,        32'h4,    1, 1, 0, 1, 32'h0000_0004);

    rst_n = 1'b0;
    fetch_ready = 1'b0;
    idle_inputs();
    #1;
    chk("reset_rv",    {31'b0, redirect_valid}, 32'h0);
    chk("reset_pc",    redirect_pc, 32'h0);
    chk("reset_stall", {31'b0, stall_id}, 32'h0);
    chk("reset_flush", {31'b0, flush_id}, 32'h0);
`ifdef BRANCH_STATS_EN
    chk("reset_stat_br", stat_branches, 32'h0);
    chk("reset_stat_tk", stat_taken, 32'h0);
    chk("reset_stat_st", stat_stall_cycles, 32'h0);
`endif
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: present one branch, check decision, then let it drain with fetch_ready=1.
    for (int i = 0; i < 10; i++) begin
      drive_br(vecs[i].valid, vecs[i].beq, vecs[i].bne, vecs[i].pc4, vecs[i].imm,
               vecs[i].rs, vecs[i].rt, vecs[i].rs_rdy, vecs[i].rt_rdy);
      fetch_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), {31'b0, stall_id}, {31'b0, vecs[i].exp_stall});
      chk($sformatf("vec%0d_flush", i), {31'b0, flush_id}, 32'h0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rv", i), {31'b0, redirect_valid}, {31'b0, vecs[i].exp_rv});
      if (vecs[i].exp_rv) chk($sformatf("vec%0d_pc", i), redirect_pc, vecs[i].exp_pc);
      id_valid = 1'b0; rs_ready = 1'b1; rt_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_accept_flush", i), {31'b0, flush_id}, {31'b0, vecs[i].exp_rv});
      chk($sformatf("vec%0d_accept_stall", i), {31'b0, stall_id}, 32'h0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rv_drop", i), {31'b0, redirect_valid}, 32'h0);
    end

    // Operand wait: rt pending 3 cycles, ID inputs changing meanwhile must be ignored.
    fetch_ready = 1'b0;
    drive_br(1'b1, 1'b1, 1'b0, 32'h0000_2000, 16'h0004, 32'h7, 32'h0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("wait_stall%0d", c), {31'b0, stall_id}, 32'h1);
      chk($sformatf("wait_rv%0d", c), {31'b0, redirect_valid}, 32'h0);
      @(posedge clk); #1;
      id_is_beq = 1'b0; id_is_bne = 1'b1; id_pc4 = 32'hDEAD_0000; id_imm = 16'h1111;
    end
    rt_val = 32'h7; rt_ready = 1'b1;
    @(negedge clk);
    chk("wait_resolve_stall", {31'b0, stall_id}, 32'h0);
    chk("wait_resolve_rv", {31'b0, redirect_valid}, 32'h0);
    @(posedge clk); #1;
    chk("wait_rv", {31'b0, redirect_valid}, 32'h1);
    chk("wait_pc", redirect_pc, 32'h0000_2010);
    id_valid = 1'b0;
    fetch_ready = 1'b1;
    @(negedge clk);
    chk("wait_flush", {31'b0, flush_id}, 32'h1);
    @(posedge clk); #1;
    chk("wait_rv_drop", {31'b0, redirect_valid}, 32'h0);

    // Backpressure: taken bne, fetch_ready low 4 cycles, wrong-path branch sits in ID.
    fetch_ready = 1'b0;
    drive_br(1'b1, 1'b0, 1'b1, 32'h0000_3000, 16'hFFFE, 32'h1, 32'h2, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive_br(1'b1, 1'b1, 1'b0, 32'h0000_9000, 16'h0001, 32'h5, 32'h6, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("hold_rv%0d", c), {31'b0, redirect_valid}, 32'h1);
      chk($sformatf("hold_pc%0d", c), redirect_pc, 32'h0000_2FF8);
      chk($sformatf("hold_stall%0d", c), {31'b0, stall_id}, 32'h1);
      chk($sformatf("hold_flush%0d", c), {31'b0, flush_id}, 32'h0);
      @(posedge clk); #1;
    end
    fetch_ready = 1'b1;
    @(negedge clk);
    chk("hold_accept_flush", {31'b0, flush_id}, 32'h1);
    chk("hold_accept_stall", {31'b0, stall_id}, 32'h0);
    chk("hold_accept_rv", {31'b0, redirect_valid}, 32'h1);
    @(posedge clk); #1;
    idle_inputs();
    chk("hold_rv_drop", {31'b0, redirect_valid}, 32'h0);
    chk("hold_pc_kept", redirect_pc, 32'h0000_2FF8);
    @(negedge clk);
    chk("hold_post_flush", {31'b0, flush_id}, 32'h0);
    chk("hold_post_stall", {31'b0, stall_id}, 32'h0);
    @(posedge clk); #1;

    // Reset while in REDIRECT.
    fetch_ready = 1'b0;
    drive_br(1'b1, 1'b1, 1'b0, 32'h0000_0500, 16'h0001, 32'h3, 32'h3, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("rst_pre_rv", {31'b0, redirect_valid}, 32'h1);
    chk("rst_pre_pc", redirect_pc, 32'h0000_0504);
    drive_br(1'b1, 1'b1, 1'b0, 32'h0000_0600, 16'h0001, 32'h3, 32'h3, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rv", {31'b0, redirect_valid}, 32'h0);
    chk("rst_pc", redirect_pc, 32'h0);
    chk("rst_stall", {31'b0, stall_id}, 32'h0);
    chk("rst_flush", {31'b0, flush_id}, 32'h0);
`ifdef BRANCH_STATS_EN
    chk("rst_stat_br", stat_branches, 32'h0);
    chk("rst_stat_tk", stat_taken, 32'h0);
    chk("rst_stat_st", stat_stall_cycles, 32'h0);
`endif
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle_inputs();
    fetch_ready = 1'b1;
    @(negedge clk);
    chk("rst_idle_flush", {31'b0, flush_id}, 32'h0);
    chk("rst_idle_stall", {31'b0, stall_id}, 32'h0);
    @(posedge clk); #1;
    chk("rst_idle_rv", {31'b0, redirect_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
